// File: rtl/trace_frame_sync.sv
// trace_frame_sync
// Deframes a 4-bit TPIU trace port stream into bytes. A sync pattern (seven
// 0xF nibbles followed by 0x7) establishes nibble alignment. Completed bytes
// pass through a 3-deep delay line so that bytes belonging to a trailing sync
// pattern (FF FF FF 7F) can be discarded before they reach byte_out.
//
// Ports
//   trace_clk     : single clock, all logic on rising edge
//   reset         : synchronous, active-high reset
//   trace_data    : TPIU trace port nibble, sampled every edge
//   resync        : single-cycle pulse, forces loss of sync
//   byte_out      : deframed trace byte
//   byte_valid    : one-cycle strobe per emitted byte
//   frame_start   : byte_valid on byte 0 of a 16-byte frame
//   synchronized  : high while in SYNCED
//   sync_count    : aligned syncs seen, saturating
//   realign_count : misaligned-sync realignments, saturating
module trace_frame_sync #(
    parameter int unsigned pSYNC_CNT_WIDTH    = 16,
    parameter int unsigned pREALIGN_CNT_WIDTH = 8
) (
    input  logic                          trace_clk,
    input  logic                          reset,
    input  logic [3:0]                    trace_data,
    input  logic                          resync,
    output logic [7:0]                    byte_out,
    output logic                          byte_valid,
    output logic                          frame_start,
    output logic                          synchronized,
    output logic [pSYNC_CNT_WIDTH-1:0]    sync_count,
    output logic [pREALIGN_CNT_WIDTH-1:0] realign_count
);

    typedef enum logic [0:0] {StHunt, StSynced} state_e;

    state_e     state_q;
    logic [2:0] run_q;          // consecutive 0xF nibbles, saturating at 7
    logic       phase_q;        // 0: next nibble is low half, 1: high half
    logic [3:0] low_q;          // pending low nibble
    logic [7:0] dl_data_q [3];  // delay line, entry 0 is oldest
    logic [2:0] dl_valid_q;
    logic [3:0] pos_q;          // frame position of the next emitted byte

    logic       sync_hit;
    logic [7:0] new_byte;

    assign sync_hit     = (trace_data == 4'h7) && (run_q == 3'd7);
    assign new_byte     = {trace_data, low_q};
    assign synchronized = (state_q == StSynced);

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            state_q       <= StHunt;
            run_q         <= 3'd0;
            phase_q       <= 1'b0;
            low_q         <= 4'h0;
            dl_valid_q    <= 3'b000;
            pos_q         <= 4'd0;
            byte_out      <= 8'h00;
            byte_valid    <= 1'b0;
            frame_start   <= 1'b0;
            sync_count    <= '0;
            realign_count <= '0;
            for (int i = 0; i < 3; i++) begin
                dl_data_q[i] <= 8'h00;
            end
        end else begin
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;

            // Any non-0xF nibble (including a sync 0x7) restarts the run.
            if (trace_data == 4'hF) begin
                if (run_q != 3'd7) begin
                    run_q <= run_q + 3'd1;
                end
            end else begin
                run_q <= 3'd0;
            end

            if (resync) begin
                // Wins over a coincident sync hit; counters are kept.
                state_q    <= StHunt;
                dl_valid_q <= 3'b000;
                phase_q    <= 1'b0;
                pos_q      <= 4'd0;
            end else begin
                unique case (state_q)
                    StHunt: begin
                        if (sync_hit) begin
                            state_q    <= StSynced;
                            phase_q    <= 1'b0;
                            pos_q      <= 4'd0;
                            dl_valid_q <= 3'b000;
                            if (sync_count != '1) begin
                                sync_count <= sync_count + pSYNC_CNT_WIDTH'(1);
                            end
                        end
                    end
                    StSynced: begin
                        if (sync_hit) begin
                            // The buffered bytes are the head of this sync
                            // pattern (or misaligned junk), so drop them all.
                            dl_valid_q <= 3'b000;
                            phase_q    <= 1'b0;
                            low_q      <= 4'h0;
                            pos_q      <= 4'd0;
                            if (phase_q) begin
                                if (sync_count != '1) begin
                                    sync_count <= sync_count + pSYNC_CNT_WIDTH'(1);
                                end
                            end else begin
                                if (realign_count != '1) begin
                                    realign_count <= realign_count + pREALIGN_CNT_WIDTH'(1);
                                end
                            end
                        end else if (!phase_q) begin
                            low_q   <= trace_data;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (&dl_valid_q) begin
                                byte_out     <= dl_data_q[0];
                                byte_valid   <= 1'b1;
                                frame_start  <= (pos_q == 4'd0);
                                pos_q        <= pos_q + 4'd1;
                                dl_data_q[0] <= dl_data_q[1];
                                dl_data_q[1] <= dl_data_q[2];
                                dl_data_q[2] <= new_byte;
                            end else if (!dl_valid_q[0]) begin
                                dl_data_q[0]  <= new_byte;
                                dl_valid_q[0] <= 1'b1;
                            end else if (!dl_valid_q[1]) begin
                                dl_data_q[1]  <= new_byte;
                                dl_valid_q[1] <= 1'b1;
                            end else begin
                                dl_data_q[2]  <= new_byte;
                                dl_valid_q[2] <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_frame_sync.sv
// tb_trace_frame_sync
// Directed bench for trace_frame_sync. A second instance with narrow counters
// shares the stimulus so counter saturation is reached in a few syncs.
module tb_trace_frame_sync;

    logic        trace_clk = 1'b0;
    logic        reset;
    logic [3:0]  trace_data;
    logic        resync;

    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        frame_start;
    logic        synchronized;
    logic [15:0] sync_count;
    logic [7:0]  realign_count;

    logic [7:0]  n_byte_out;
    logic        n_byte_valid;
    logic        n_frame_start;
    logic        n_synchronized;
    logic [1:0]  n_sync_count;
    logic [0:0]  n_realign_count;

    trace_frame_sync u_dut (
        .trace_clk     (trace_clk),
        .reset         (reset),
        .trace_data    (trace_data),
        .resync        (resync),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .frame_start   (frame_start),
        .synchronized  (synchronized),
        .sync_count    (sync_count),
        .realign_count (realign_count)
    );

    trace_frame_sync #(
        .pSYNC_CNT_WIDTH    (2),
        .pREALIGN_CNT_WIDTH (1)
    ) u_dut_narrow (
        .trace_clk     (trace_clk),
        .reset         (reset),
        .trace_data    (trace_data),
        .resync        (resync),
        .byte_out      (n_byte_out),
        .byte_valid    (n_byte_valid),
        .frame_start   (n_frame_start),
        .synchronized  (n_synchronized),
        .sync_count    (n_sync_count),
        .realign_count (n_realign_count)
    );

    always #5 trace_clk = ~trace_clk;

    int unsigned cyc = 0;
    always @(posedge trace_clk) cyc <= cyc + 1;

    // Every emitted byte, captured away from the active edge.
    logic [7:0]  log_byte [$];
    logic        log_fs   [$];
    int unsigned log_cyc  [$];
    always @(negedge trace_clk) begin
        if (byte_valid === 1'b1) begin
            log_byte.push_back(byte_out);
            log_fs.push_back(frame_start);
            log_cyc.push_back(cyc);
        end
    end

    logic [7:0] exp_byte [$];
    logic       exp_fs   [$];

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned sync_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        @(negedge trace_clk);
        trace_data = n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[3:0]);
        send_nib(b[7:4]);
    endtask

    task automatic send_sync();
        repeat (7) send_nib(4'hF);
        send_nib(4'h7);
    endtask

    task automatic settle();
        @(posedge trace_clk);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic fs);
        exp_byte.push_back(b);
        exp_fs.push_back(fs);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_byte_out"}, 32'(byte_out), 32'h0);
        check_val({tag, "_byte_valid"}, 32'(byte_valid), 32'h0);
        check_val({tag, "_frame_start"}, 32'(frame_start), 32'h0);
        check_val({tag, "_synchronized"}, 32'(synchronized), 32'h0);
        check_val({tag, "_sync_count"}, 32'(sync_count), 32'h0);
        check_val({tag, "_realign_count"}, 32'(realign_count), 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        trace_data = 4'h0;
        resync     = 1'b0;
        repeat (3) @(posedge trace_clk);
        #1;
        check_all_zero("reset");
        @(negedge trace_clk);
        reset = 1'b0;

        // Initial sync from HUNT, then four bytes.
        repeat (7) send_nib(4'hF);
        settle();
        check_val("hunt_before_7", 32'(synchronized), 32'h0);
        send_nib(4'h7);
        settle();
        sync_cyc = cyc;
        check_val("first_sync_locked", 32'(synchronized), 32'h1);
        check_val("first_sync_count", 32'(sync_count), 32'h1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        expect_byte(8'h11, 1'b1);
        expect_byte(8'h22, 1'b0);
        expect_byte(8'h33, 1'b0);
        expect_byte(8'h44, 1'b0);

        // Aligned sync: FF FF FF 7F, none of it emitted.
        send_sync();
        settle();
        check_val("aligned_sync_count", 32'(sync_count), 32'h2);
        check_val("aligned_still_locked", 32'(synchronized), 32'h1);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hD4);
        expect_byte(8'hA1, 1'b1);

        // One stray nibble shifts alignment, then a full sync realigns.
        send_nib(4'h5);
        send_sync();
        settle();
        check_val("realign_count", 32'(realign_count), 32'h1);
        check_val("realign_locked", 32'(synchronized), 32'h1);
        check_val("realign_sync_count", 32'(sync_count), 32'h2);
        expect_byte(8'hB2, 1'b0);
        expect_byte(8'hC3, 1'b0);
        expect_byte(8'hD4, 1'b0);
        expect_byte(8'hF5, 1'b0);

        // 40 bytes: frame_start on emitted bytes 0, 16 and 32.
        for (int k = 0; k < 40; k++) begin
            send_byte(8'(8'h40 + k));
            expect_byte(8'(8'h40 + k), ((k % 16) == 0));
        end

        // resync coincident with the final 0x7 of a sync pattern.
        repeat (7) send_nib(4'hF);
        @(negedge trace_clk);
        trace_data = 4'h7;
        resync     = 1'b1;
        settle();
        check_val("resync_unlocked", 32'(synchronized), 32'h0);
        check_val("resync_sync_count", 32'(sync_count), 32'h2);
        check_val("resync_realign_count", 32'(realign_count), 32'h1);
        @(negedge trace_clk);
        resync = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h99);
        settle();
        check_val("hunt_ignores_data", 32'(synchronized), 32'h0);

        // Repeated syncs drive the narrow counters into saturation.
        send_sync();
        settle();
        check_val("sat_sync3", 32'(sync_count), 32'h3);
        check_val("sat_narrow3", 32'(n_sync_count), 32'h3);
        send_sync();
        settle();
        check_val("sat_sync4", 32'(sync_count), 32'h4);
        check_val("sat_narrow_hold", 32'(n_sync_count), 32'h3);
        send_sync();
        settle();
        check_val("sat_sync5", 32'(sync_count), 32'h5);
        check_val("sat_narrow_hold2", 32'(n_sync_count), 32'h3);
        send_nib(4'h3);
        send_sync();
        settle();
        check_val("sat_realign2", 32'(realign_count), 32'h2);
        check_val("sat_narrow_realign", 32'(n_realign_count), 32'h1);
        expect_byte(8'hF3, 1'b1);

        // Reset in the middle of a byte and frame.
        send_byte(8'h21);
        send_byte(8'h32);
        send_nib(4'h3);
        settle();
        check_val("pre_reset_byte_out", 32'(byte_out), 32'hF3);
        @(negedge trace_clk);
        reset = 1'b1;
        settle();
        check_all_zero("midframe_reset");
        check_val("midframe_reset_narrow", 32'(n_sync_count), 32'h0);
        @(negedge trace_clk);
        reset = 1'b0;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        send_byte(8'h9A);
        repeat (4) @(posedge trace_clk);
        #1;
        check_val("post_reset_unlocked", 32'(synchronized), 32'h0);

        // Emitted byte log against the hand-built expectation.
        check_val("log_count", 32'(log_byte.size()), 32'(exp_byte.size()));
        if (log_cyc.size() > 0) begin
            check_val("first_byte_latency", 32'(log_cyc[0] - sync_cyc), 32'd8);
        end else begin
            check_val("first_byte_seen", 32'h0, 32'h1);
        end
        for (int i = 0; i < exp_byte.size(); i++) begin
            if (i < log_byte.size()) begin
                check_val($sformatf("byte[%0d]", i), 32'(log_byte[i]), 32'(exp_byte[i]));
                check_val($sformatf("fs[%0d]", i), 32'(log_fs[i]), 32'(exp_fs[i]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_frame_sync.md
TRACE_FRAME_SYNC -- requirements
Module: trace_frame_sync

Interface
- REQ-001: Parameter pSYNC_CNT_WIDTH, default 16, SHALL set the width of sync_count.
- REQ-002: Parameter pREALIGN_CNT_WIDTH, default 8, SHALL set the width of realign_count.
- REQ-003: trace_clk  input  1  SHALL be the single clock; all logic SHALL be on its rising edge.
- REQ-004: reset  input  1  SHALL be a synchronous, active-high reset.
- REQ-005: trace_data  input  4  SHALL carry the TPIU trace port nibble, sampled every trace_clk edge.
- REQ-006: resync  input  1  SHALL be a single-cycle pulse from the register block that forces loss of sync.
- REQ-007: byte_out  output  8  SHALL carry the deframed trace byte.
- REQ-008: byte_valid  output  1  SHALL mark byte_out valid for exactly one cycle per byte.
- REQ-009: frame_start  output  1  SHALL be asserted with byte_valid on byte 0 of each 16-byte TPIU frame.
- REQ-010: synchronized  output  1  SHALL be high while in state SYNCED.
- REQ-011: sync_count  output  pSYNC_CNT_WIDTH  SHALL count aligned syncs, saturating.
- REQ-012: realign_count  output  pREALIGN_CNT_WIDTH  SHALL count misaligned-sync realignments, saturating.

Function
- REQ-013: The sync detector SHALL keep a 3-bit run counter of consecutive 0xF nibbles: +1 on 0xF, saturating at 7, and cleared on any other nibble.
- REQ-014: A sync hit SHALL occur when the sampled nibble is 0x7 and the run counter equals 7; a hit SHALL clear the run counter.
- REQ-015: The FSM SHALL have exactly two states, HUNT and SYNCED; in HUNT, no byte_valid SHALL be produced.
- REQ-016: HUNT->SYNCED SHALL occur on a sync hit; nibble phase, frame position and delay line SHALL clear, and sync_count SHALL increment.
- REQ-017: In SYNCED, the phase bit SHALL alternate per nibble.
  - Phase 0 nibble = low nibble of the byte.
  - Phase 1 nibble = high nibble; that edge completes the byte.
- REQ-018: Completed bytes SHALL enter a 3-entry delay line with per-entry valid bits.
- REQ-019: A push into a full delay line SHALL emit its oldest entry on byte_out with byte_valid high the following cycle.
  - Byte n is therefore emitted one cycle after byte n+3 completes.
- REQ-020: Aligned sync (hit on a phase-1 nibble in SYNCED) SHALL:
  - discard the completing byte and all delay-line entries (no output);
  - reset frame position to 0;
  - increment sync_count.
- REQ-021: Misaligned sync (hit on a phase-0 nibble in SYNCED) SHALL:
  - discard the delay line and the pending low nibble;
  - force the next nibble to phase 0;
  - reset frame position to 0;
  - increment realign_count;
  - remain in SYNCED.
- REQ-022: The 4-bit frame position SHALL increment on each emitted byte, wrapping 15->0.
  - frame_start = byte_valid AND position==0.
- REQ-023: resync SHALL move to HUNT next edge, clearing the delay line, phase and frame position; counters SHALL be preserved.
- REQ-024: resync SHALL take precedence over a simultaneous sync hit.
- REQ-025: Both counters SHALL hold at all-ones instead of wrapping.

Reset
- REQ-026: reset SHALL force state HUNT, and clear the run counter, phase, delay line and frame position.
- REQ-027: On reset, all outputs SHALL go to 0 on the next edge: byte_out, byte_valid, frame_start, synchronized, sync_count, realign_count.
- REQ-028: reset asserted mid-byte or mid-frame SHALL drop all partial data, with no byte_valid afterwards until a new sync and 4 completed bytes.

Verification
- REQ-029: Nibbles F x7, 7, then low/high pairs for bytes 0x11,0x22,0x33,0x44 -> synchronized=1 after the 0x7 edge; first byte_valid with byte_out=0x11, frame_start=1, eight cycles after the sync edge.
- REQ-030: Synced stream, then FF FF FF 7F as nibbles F,F,F,F,F,F,F,7 -> none of those four bytes emitted; sync_count +1; next data byte emitted with frame_start=1.
- REQ-031: Synced stream, then a single extra nibble followed by a full sync -> realign_count=1, synchronized stays 1, following bytes correctly aligned.
- REQ-032: 40 data bytes after sync -> frame_start on emitted bytes 0, 16 and 32 only.
- REQ-033: resync pulse coincident with the final 0x7 of a sync -> synchronized=0, sync_count unchanged.
- REQ-034: sync_count preloaded by forcing to 0xFFFE, then 3 aligned syncs -> 0xFFFF; reset mid-frame -> all outputs 0 next cycle.
